// File: rtl/inst_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry and the
// instruction word type used by the cache and its storage arrays.
package inst_cache_pkg;

  localparam int DEF_INDEX_W = 7;   // 128 lines of one word each
  localparam int DEF_ADDR_W  = 32;  // byte address width
  localparam int INST_W      = 32;  // instruction word width

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/inst_cache_ram.sv
// Valid/tag/data arrays for the direct-mapped instruction cache.
// One combinational read port, one synchronous write port. Only the valid
// bits are reset; tag and data contents are meaningless until filled.
module inst_cache_ram
  import inst_cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [INST_W-1:0]  rd_data,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [INST_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays: written on fill only.
  // NOTE: no reset on these arrays -- a line is only ever read through its
  // valid bit, so resetting them would add reset fan-out and block RAM
  // inference for no functional gain.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and
// the memory controller. Hits answer one cycle after the request; misses are
// forwarded to memctrl and the returned word is filled and passed on.
// clr abandons in-flight work but keeps cache contents.
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              iINF_en,
  input  logic [ADDR_W-1:0] iINF_pc,
  output logic              oINF_done,
  output logic [INST_W-1:0] oINF_inst,
  output logic              oMC_en,
  output logic [ADDR_W-1:0] oMC_pc,
  input  logic              iMC_done,
  input  logic [INST_W-1:0] iMC_inst
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic {
    S_IDLE,
    S_MISS
  } state_t;

  state_t state_q;

  logic [INDEX_W-1:0] lookup_index;
  logic [TAG_W-1:0]   lookup_tag;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [INST_W-1:0]  line_data;
  logic               hit;
  logic               fill_en;
  logic               unused_pc_bits;

  // Lookups use the live fetch address; fills use the latched miss address,
  // which is exactly what is presented on oMC_pc during MISS.
  assign lookup_index   = iINF_pc[INDEX_W+1:2];
  assign lookup_tag     = iINF_pc[ADDR_W-1:INDEX_W+2];
  assign fill_index     = oMC_pc[INDEX_W+1:2];
  assign fill_tag       = oMC_pc[ADDR_W-1:INDEX_W+2];
  assign hit            = line_valid && (line_tag == lookup_tag);
  assign unused_pc_bits = ^iINF_pc[1:0];

  // A fill happens only when memctrl answers a live, un-flushed miss.
  assign fill_en = rdy && !clr && (state_q == S_MISS) && iMC_done;

  inst_cache_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (lookup_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .we       (fill_en),
    .wr_index (fill_index),
    .wr_tag   (fill_tag),
    .wr_data  (iMC_inst)
  );

  // Control FSM with registered outputs; rdy low freezes everything.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      oINF_done <= 1'b0;
      oINF_inst <= '0;
      oMC_en    <= 1'b0;
      oMC_pc    <= '0;
    end else if (rdy) begin
      oINF_done <= 1'b0;
      if (clr) begin
        state_q <= S_IDLE;
        oMC_en  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // While done is high the fetcher's pc is stale: ignore it.
            if (iINF_en && !oINF_done) begin
              if (hit) begin
                oINF_done <= 1'b1;
                oINF_inst <= line_data;
              end else begin
                state_q <= S_MISS;
                oMC_en  <= 1'b1;
                oMC_pc  <= {iINF_pc[ADDR_W-1:2], 2'b00};
              end
            end
          end
          S_MISS: begin
            if (iMC_done) begin
              state_q   <= S_IDLE;
              oMC_en    <= 1'b0;
              oINF_done <= 1'b1;
              oINF_inst <= iMC_inst;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed testbench for inst_cache. A cycle-level behavioural model (a
// word-addressed cache map plus a "waiting on memory" flag) predicts every
// output; a negedge process compares DUT against it each cycle, and the
// directed sequence adds hand-computed literal expectations.
module tb_inst_cache;

  localparam int INDEX_W = 7;
  localparam int ADDR_W  = 32;
  localparam int LINES   = 1 << INDEX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              clr;
  logic              iINF_en;
  logic [ADDR_W-1:0] iINF_pc;
  logic              oINF_done;
  logic [31:0]       oINF_inst;
  logic              oMC_en;
  logic [ADDR_W-1:0] oMC_pc;
  logic              iMC_done;
  logic [31:0]       iMC_inst;

  int n_checks = 0;
  int n_errors = 0;

  inst_cache #(
    .INDEX_W (INDEX_W),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .clr       (clr),
    .iINF_en   (iINF_en),
    .iINF_pc   (iINF_pc),
    .oINF_done (oINF_done),
    .oINF_inst (oINF_inst),
    .oMC_en    (oMC_en),
    .oMC_pc    (oMC_pc),
    .iMC_done  (iMC_done),
    .iMC_inst  (iMC_inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The cache is a map from line number to the full word address it holds.
  logic        m_valid [LINES];
  logic [29:0] m_word  [LINES];
  logic [31:0] m_data  [LINES];
  logic        m_done;
  logic [31:0] m_inst;
  logic        m_mc_en;
  logic [31:0] m_mc_pc;

  always @(posedge clk or negedge rst) begin
    int          idx;
    logic [29:0] word;
    if (!rst) begin
      for (int i = 0; i < LINES; i++) m_valid[i] <= 1'b0;
      m_done  <= 1'b0;
      m_inst  <= '0;
      m_mc_en <= 1'b0;
      m_mc_pc <= '0;
    end else if (rdy) begin
      m_done <= 1'b0;
      if (clr) begin
        m_mc_en <= 1'b0;
      end else if (m_mc_en) begin
        if (iMC_done) begin
          idx = int'(m_mc_pc[31:2]) % LINES;
          m_valid[idx] <= 1'b1;
          m_word[idx]  <= m_mc_pc[31:2];
          m_data[idx]  <= iMC_inst;
          m_done       <= 1'b1;
          m_inst       <= iMC_inst;
          m_mc_en      <= 1'b0;
        end
      end else if (iINF_en && !m_done) begin
        word = iINF_pc[31:2];
        idx  = int'(word) % LINES;
        if (m_valid[idx] && m_word[idx] == word) begin
          m_done <= 1'b1;
          m_inst <= m_data[idx];
        end else begin
          m_mc_en <= 1'b1;
          m_mc_pc <= {word, 2'b00};
        end
      end
    end
  end

  // Compare DUT with the model on every falling edge.
  always @(negedge clk) begin
    check("done", {31'b0, oINF_done}, {31'b0, m_done});
    check("inst", oINF_inst, m_inst);
    check("mc_en", {31'b0, oMC_en}, {31'b0, m_mc_en});
    check("mc_pc", oMC_pc, m_mc_pc);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clr = 1'b0; iINF_en = 1'b0; iINF_pc = '0;
    iMC_done = 1'b0; iMC_inst = '0;
    step(); step();
    check("reset_done", {31'b0, oINF_done}, 32'd0);
    check("reset_mc_en", {31'b0, oMC_en}, 32'd0);
    check("reset_inst", oINF_inst, 32'd0);
    check("reset_mc_pc", oMC_pc, 32'd0);
    rst = 1'b1;
    step();

    // Cold miss on 0x0
    iINF_en = 1'b1; iINF_pc = 32'h0;
    step();
    check("cold_mc_en", {31'b0, oMC_en}, 32'd1);
    check("cold_mc_pc", oMC_pc, 32'h0);
    iMC_done = 1'b1; iMC_inst = 32'h0000_0513;
    step();
    check("cold_done", {31'b0, oINF_done}, 32'd1);
    check("cold_inst", oINF_inst, 32'h0000_0513);
    check("cold_mc_off", {31'b0, oMC_en}, 32'd0);
    iMC_done = 1'b0; iINF_en = 1'b0;
    step();

    // Stray iMC_done in IDLE is ignored
    iMC_done = 1'b1; iMC_inst = 32'hFFFF_FFFF;
    step();
    check("stray_done", {31'b0, oINF_done}, 32'd0);
    iMC_done = 1'b0;

    // Hit, stale-pc ignore, then back-to-back hit
    iINF_en = 1'b1; iINF_pc = 32'h0;
    step();
    check("hit_done", {31'b0, oINF_done}, 32'd1);
    check("hit_inst", oINF_inst, 32'h0000_0513);
    check("hit_no_mc", {31'b0, oMC_en}, 32'd0);
    step();
    check("stale_ignored", {31'b0, oINF_done}, 32'd0);
    check("stale_no_mc", {31'b0, oMC_en}, 32'd0);
    step();
    check("b2b_done", {31'b0, oINF_done}, 32'd1);
    iINF_en = 1'b0;
    step();

    // Conflict eviction: 0x200 maps to the same line as 0x0
    iINF_en = 1'b1; iINF_pc = 32'h200;
    step();
    check("conf_mc_en", {31'b0, oMC_en}, 32'd1);
    check("conf_mc_pc", oMC_pc, 32'h200);
    iMC_done = 1'b1; iMC_inst = 32'h0010_0093;
    step();
    check("conf_inst", oINF_inst, 32'h0010_0093);
    iMC_done = 1'b0; iINF_en = 1'b0;
    step();
    iINF_en = 1'b1; iINF_pc = 32'h0;
    step();
    check("evict_mc_en", {31'b0, oMC_en}, 32'd1);
    check("evict_mc_pc", oMC_pc, 32'h0);
    iMC_done = 1'b1; iMC_inst = 32'h0000_0513;
    step();
    iMC_done = 1'b0; iINF_en = 1'b0;
    step();

    // Flush: clr together with iMC_done abandons the fill
    iINF_en = 1'b1; iINF_pc = 32'h4;
    step();
    check("flush_mc_pc", oMC_pc, 32'h4);
    clr = 1'b1; iMC_done = 1'b1; iMC_inst = 32'hDEAD_BEEF; iINF_en = 1'b0;
    step();
    check("flush_no_done", {31'b0, oINF_done}, 32'd0);
    check("flush_mc_off", {31'b0, oMC_en}, 32'd0);
    clr = 1'b0; iMC_done = 1'b0;
    step();
    iINF_en = 1'b1; iINF_pc = 32'h4;
    step();
    check("flush_still_miss", {31'b0, oMC_en}, 32'd1);

    // Stall: rdy low for three cycles while memctrl pulses done
    rdy = 1'b0; iMC_done = 1'b1; iMC_inst = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_mc_en", {31'b0, oMC_en}, 32'd1);
      check("stall_no_done", {31'b0, oINF_done}, 32'd0);
    end
    rdy = 1'b1; iMC_inst = 32'h0040_0113;
    step();
    check("stall_done", {31'b0, oINF_done}, 32'd1);
    check("stall_inst", oINF_inst, 32'h0040_0113);
    iMC_done = 1'b0; iINF_en = 1'b0;
    step();
    iINF_en = 1'b1; iINF_pc = 32'h4;
    step();
    check("fill4_hit", oINF_inst, 32'h0040_0113);
    check("fill4_no_mc", {31'b0, oMC_en}, 32'd0);
    iINF_en = 1'b0;
    step();

    // Async reset in the middle of a miss
    iINF_en = 1'b1; iINF_pc = 32'h8;
    step();
    check("pre_rst_mc_pc", oMC_pc, 32'h8);
    #2 rst = 1'b0;
    #1;
    check("arst_mc_en", {31'b0, oMC_en}, 32'd0);
    check("arst_mc_pc", oMC_pc, 32'd0);
    check("arst_done", {31'b0, oINF_done}, 32'd0);
    check("arst_inst", oINF_inst, 32'd0);
    iINF_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    iINF_en = 1'b1; iINF_pc = 32'h0;
    step();
    check("post_rst_miss", {31'b0, oMC_en}, 32'd1);
    iMC_done = 1'b1; iMC_inst = 32'h0000_0513;
    step();
    check("post_rst_inst", oINF_inst, 32'h0000_0513);
    iMC_done = 1'b0; iINF_en = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
